// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs and mux selects.
// MC_CTRL_MDU_EN enables decoding of the multiply/divide group and HI/LO reads.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        MDUW   = 3'd5
    } mcState_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_LUI = 4'd3;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_DM   = 2'b01;
    localparam logic [1:0] WD_PC   = 2'b10;
    localparam logic [1:0] WD_HILO = 2'b11;

    localparam logic [1:0] REG_RD = 2'b00;
    localparam logic [1:0] REG_RT = 2'b01;
    localparam logic [1:0] REG_RA = 2'b10;

`ifdef MC_CTRL_MDU_EN
    localparam logic MDU_BUILT = 1'b1;
`else
    localparam logic MDU_BUILT = 1'b0;
`endif

    // Exactly one flag is set for any instruction word.
    typedef struct packed {
        logic nop;
        logic jump;
        logic jal;
        logic jr;
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic mfhi;
        logic mflo;
        logic mdu;
        logic illegal;
    } instrClass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR/status into the controller, enables and mux selects out.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             mem_ready;
    logic             pc_we;
    logic             ir_we;
    logic             grf_we;
    logic             dm_we;
    logic             mem_req;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic             ext_sign;
    logic [1:0]       npc_sel;
    logic             mdu_start;
    logic             hilo_sel;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, zero, mem_ready,
        output pc_we, ir_we, grf_we, dm_we, mem_req, reg_dst, wd_sel, alu_src,
               alu_op, ext_sign, npc_sel, mdu_start, hilo_sel, illegal, state, retired
    );

    modport slave (
        output instr, zero, mem_ready,
        input  pc_we, ir_we, grf_we, dm_we, mem_req, reg_dst, wd_sel, alu_src,
               alu_op, ext_sign, npc_sel, mdu_start, hilo_sel, illegal, state, retired
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: IR word -> one-hot class flags.
// With MC_CTRL_MDU_EN undefined the MDU group and mfhi/mflo classify as illegal.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output instrClass_t cls
);
    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        cls = '0;
        if (instr == 32'd0) begin
            cls.nop = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADDU: cls.addu = 1'b1;
                        FN_SUBU: cls.subu = 1'b1;
                        FN_JR:   cls.jr   = 1'b1;
                        // HI/LO reads and MDU launches only exist when the MDU is built in
                        FN_MFHI: begin
                            cls.mfhi    = MDU_BUILT;
                            cls.illegal = !MDU_BUILT;
                        end
                        FN_MFLO: begin
                            cls.mflo    = MDU_BUILT;
                            cls.illegal = !MDU_BUILT;
                        end
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            cls.mdu     = MDU_BUILT;
                            cls.illegal = !MDU_BUILT;
                        end
                        default: cls.illegal = 1'b1;
                    endcase
                end
                OP_J:    cls.jump = 1'b1;
                OP_JAL:  cls.jal  = 1'b1;
                OP_BEQ:  cls.beq  = 1'b1;
                OP_ORI:  cls.ori  = 1'b1;
                OP_LUI:  cls.lui  = 1'b1;
                OP_LW:   cls.lw   = 1'b1;
                OP_SW:   cls.sw   = 1'b1;
                default: cls.illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing, MDU wait, retired counter.
// MC_CTRL_MDU_EN builds the MDUW state, its latency counter, mdu_start and hilo_sel.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int MDU_LAT = 5
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    instrClass_t      cls;
    mcState_t         stateReg;
    mcState_t         stateNext;
    logic [CNT_W-1:0] retiredReg;
    logic             pcWe;
    logic             irWe;
    logic             grfWe;
    logic             dmWe;
    logic             memReq;
    logic             illegalPulse;

    mc_decode uDecode (
        .instr (bus.instr),
        .cls   (cls)
    );

`ifdef MC_CTRL_MDU_EN
    localparam logic [7:0] MDU_LOAD = 8'(MDU_LAT - 1);
    localparam mcState_t   MDU_NEXT = MDUW;
    logic [7:0] mduCntReg;

    // Loaded while leaving EXEC so the first MDUW cycle already reads MDU_LAT-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mduCntReg <= 8'd0;
        end else if (stateReg == EXEC && cls.mdu) begin
            mduCntReg <= MDU_LOAD;
        end else if (stateReg == MDUW && mduCntReg != 8'd0) begin
            mduCntReg <= mduCntReg - 8'd1;
        end
    end
`else
    localparam mcState_t   MDU_NEXT = FETCH;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= FETCH;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retiredReg <= '0;
        end else if (stateReg != FETCH && stateNext == FETCH) begin
            retiredReg <= retiredReg + 1'b1;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        pcWe         = 1'b0;
        irWe         = 1'b0;
        grfWe        = 1'b0;
        dmWe         = 1'b0;
        memReq       = 1'b0;
        illegalPulse = 1'b0;
        case (stateReg)
            FETCH: begin
                irWe      = 1'b1;
                pcWe      = 1'b1;
                stateNext = DECODE;
            end
            DECODE: begin
                stateNext    = EXEC;
                pcWe         = cls.jump | cls.jal | cls.jr;
                grfWe        = cls.jal;
                illegalPulse = cls.illegal;
                if (cls.nop | cls.jump | cls.jal | cls.jr | cls.illegal) begin
                    stateNext = FETCH;
                end
            end
            EXEC: begin
                stateNext = FETCH;
                if (cls.lw | cls.sw) begin
                    stateNext = MEM;
                end else if (cls.beq) begin
                    pcWe = bus.zero;
                end else if (cls.mdu) begin
                    stateNext = MDU_NEXT;
                end else if (cls.addu | cls.subu | cls.ori | cls.lui | cls.mfhi | cls.mflo) begin
                    stateNext = WB;
                end
            end
            MEM: begin
                memReq = 1'b1;
                dmWe   = cls.sw;
                if (bus.mem_ready) begin
                    stateNext = cls.lw ? WB : FETCH;
                end
            end
            WB: begin
                grfWe     = 1'b1;
                stateNext = FETCH;
            end
`ifdef MC_CTRL_MDU_EN
            MDUW: begin
                if (mduCntReg == 8'd0) begin
                    stateNext = FETCH;
                end
            end
`endif
            default: stateNext = FETCH;
        endcase
    end

    // Strobes are masked by reset directly so they fall the instant reset rises
    assign bus.pc_we    = pcWe & ~reset;
    assign bus.ir_we    = irWe & ~reset;
    assign bus.grf_we   = grfWe & ~reset;
    assign bus.dm_we    = dmWe & ~reset;
    assign bus.mem_req  = memReq & ~reset;
    assign bus.illegal  = illegalPulse & ~reset;
    assign bus.state    = stateReg;
    assign bus.retired  = retiredReg;

`ifdef MC_CTRL_MDU_EN
    assign bus.mdu_start = (stateReg == EXEC) & cls.mdu & ~reset;
    assign bus.hilo_sel  = cls.mfhi;
`else
    assign bus.mdu_start = 1'b0;
    assign bus.hilo_sel  = 1'b0;
`endif

    assign bus.reg_dst  = cls.jal ? REG_RA : ((cls.ori | cls.lui | cls.lw) ? REG_RT : REG_RD);
    assign bus.wd_sel   = cls.jal ? WD_PC : (cls.lw ? WD_DM : ((cls.mfhi | cls.mflo) ? WD_HILO : WD_ALU));
    assign bus.alu_src  = cls.ori | cls.lui | cls.lw | cls.sw;
    assign bus.alu_op   = (cls.subu | cls.beq) ? ALU_SUB :
                          (cls.ori ? ALU_OR : (cls.lui ? ALU_LUI : ALU_ADD));
    assign bus.ext_sign = cls.lw | cls.sw | cls.beq;
    assign bus.npc_sel  = (stateReg == FETCH) ? NPC_SEQ :
                          ((cls.jump | cls.jal) ? NPC_JMP :
                          (cls.jr ? NPC_JR : (cls.beq ? NPC_BR : NPC_SEQ)));
endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: per-instruction state/enable/select expectations from an instruction-level model.
// Honors MC_CTRL_MDU_EN the same way the design does.
module tb_mc_ctrl;
    localparam int CNT_W   = 4;
    localparam int MDU_LAT = 5;
`ifdef MC_CTRL_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_U = 5;
    localparam int K_NOP = 0, K_J = 1, K_JAL = 2, K_JR = 3, K_ADDU = 4, K_SUBU = 5, K_ORI = 6,
                   K_LUI = 7, K_LW = 8, K_SW = 9, K_BEQ = 10, K_MFHI = 11, K_MFLO = 12,
                   K_MDU = 13, K_ILL = 14;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   retModel = 0;
    logic [6:0] enVec;

    mc_ctrl_if #(.CNT_W(CNT_W)) bus();

    mc_ctrl #(.CNT_W(CNT_W), .MDU_LAT(MDU_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign enVec = {bus.pc_we, bus.ir_we, bus.grf_we, bus.dm_we, bus.mem_req, bus.mdu_start, bus.illegal};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int effKind(input int kind);
        if (!MDU_EN && (kind == K_MFHI || kind == K_MFLO || kind == K_MDU)) return K_ILL;
        return kind;
    endfunction

    function automatic logic [31:0] genInstr(input int kind);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] ins;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        case (kind)
            K_NOP:  ins = 32'h0;
            K_J:    ins = {6'h02, 26'($urandom)};
            K_JAL:  ins = {6'h03, 26'($urandom)};
            K_JR:   ins = {6'h00, rs, 15'h0, 6'h08};
            K_ADDU: ins = {6'h00, rs, rt, rd, 5'h0, 6'h21};
            K_SUBU: ins = {6'h00, rs, rt, rd, 5'h0, 6'h23};
            K_ORI:  ins = {6'h0D, rs, rt, imm};
            K_LUI:  ins = {6'h0F, 5'h0, rt, imm};
            K_LW:   ins = {6'h23, rs, rt, imm};
            K_SW:   ins = {6'h2B, rs, rt, imm};
            K_BEQ:  ins = {6'h04, rs, rt, imm};
            K_MFHI: ins = {16'h0, rd, 5'h0, 6'h10};
            K_MFLO: ins = {16'h0, rd, 5'h0, 6'h12};
            K_MDU:  ins = {6'h00, rs, rt, 10'h0, 6'(24 + $urandom_range(0, 3))};
            default: ins = ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)}
                                                       : {6'h00, rs, rt, rd, 5'h0, 6'h2A};
        endcase
        return ins;
    endfunction

    // {pc_we, ir_we, grf_we, dm_we, mem_req, mdu_start, illegal} expected in a given phase
    function automatic logic [6:0] expEn(input int k, input int st, input logic z);
        logic [6:0] e;
        e = '0;
        case (st)
            S_F: e = 7'b1100000;
            S_D: e = {(k == K_J || k == K_JAL || k == K_JR), 1'b0, (k == K_JAL), 3'b000, (k == K_ILL)};
            S_E: e = {(k == K_BEQ) && z, 4'b0000, (k == K_MDU), 1'b0};
            S_M: e = {3'b000, (k == K_SW), 1'b1, 2'b00};
            S_W: e = 7'b0010000;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic checkMux(input int k, input int st);
        logic [3:0] aluOp;
        logic       aluSrc;
        logic       ext;
        if (st == S_F) checkVal("npc_fetch", 32'(bus.npc_sel), 32'd0);
        if (st == S_D && (k == K_J || k == K_JAL)) checkVal("npc_jump", 32'(bus.npc_sel), 32'd2);
        if (st == S_D && k == K_JR) checkVal("npc_jr", 32'(bus.npc_sel), 32'd3);
        if (st == S_D && k == K_JAL) begin
            checkVal("jal_reg_dst", 32'(bus.reg_dst), 32'd2);
            checkVal("jal_wd_sel", 32'(bus.wd_sel), 32'd2);
        end
        if (st == S_E && k == K_BEQ) checkVal("npc_beq", 32'(bus.npc_sel), 32'd1);
        if ((st == S_E || st == S_W) && (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ})) begin
            case (k)
                K_SUBU:  {aluOp, aluSrc, ext} = {4'd1, 1'b0, 1'b0};
                K_ORI:   {aluOp, aluSrc, ext} = {4'd2, 1'b1, 1'b0};
                K_LUI:   {aluOp, aluSrc, ext} = {4'd3, 1'b1, 1'b0};
                K_LW:    {aluOp, aluSrc, ext} = {4'd0, 1'b1, 1'b1};
                K_SW:    {aluOp, aluSrc, ext} = {4'd0, 1'b1, 1'b1};
                K_BEQ:   {aluOp, aluSrc, ext} = {4'd1, 1'b0, 1'b1};
                default: {aluOp, aluSrc, ext} = {4'd0, 1'b0, 1'b0};
            endcase
            checkVal("alu_op", 32'(bus.alu_op), 32'(aluOp));
            checkVal("alu_src", 32'(bus.alu_src), 32'(aluSrc));
            checkVal("ext_sign", 32'(bus.ext_sign), 32'(ext));
        end
        if (st == S_W) begin
            checkVal("wb_reg_dst", 32'(bus.reg_dst), (k inside {K_ORI, K_LUI, K_LW}) ? 32'd1 : 32'd0);
            checkVal("wb_wd_sel", 32'(bus.wd_sel),
                     (k == K_LW) ? 32'd1 : ((k inside {K_MFHI, K_MFLO}) ? 32'd3 : 32'd0));
            if (k inside {K_MFHI, K_MFLO}) checkVal("hilo_sel", 32'(bus.hilo_sel), 32'(k == K_MFHI));
        end
    endtask

    // Called at a falling edge with the controller expected in FETCH
    task automatic runInstr(input int kind, input logic [31:0] ins, input int w, input logic z);
        int k;
        int seq[$];
        int memIdx;
        k = effKind(kind);
        seq.push_back(S_F);
        seq.push_back(S_D);
        if (!(k inside {K_NOP, K_J, K_JAL, K_JR, K_ILL})) seq.push_back(S_E);
        if (k == K_LW || k == K_SW) for (int i = 0; i <= w; i++) seq.push_back(S_M);
        if (k == K_MDU) for (int i = 0; i < MDU_LAT; i++) seq.push_back(S_U);
        if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_MFHI, K_MFLO, K_LW}) seq.push_back(S_W);
        bus.instr = ins;
        bus.zero  = z;
        memIdx    = 0;
        foreach (seq[i]) begin
            if (seq[i] == S_M) begin
                bus.mem_ready = (memIdx >= w);
                memIdx++;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            checkVal("state", 32'(bus.state), 32'(seq[i]));
            checkVal("enables", 32'(enVec), 32'(expEn(k, seq[i], z)));
            checkMux(k, seq[i]);
            @(posedge clk);
            @(negedge clk);
        end
        retModel = (retModel + 1) % (1 << CNT_W);
        checkVal("retired", 32'(bus.retired), 32'(retModel));
        $display("instr=%08h kind=%0d wait=%0d zero=%0d cycles=%0d retired=%0d",
                 ins, k, w, z, seq.size(), bus.retired);
    endtask

    task automatic runRandom();
        int kind;
        kind = $urandom_range(0, 14);
        runInstr(kind, genInstr(kind), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    task automatic swResetAbort();
        bus.instr     = genInstr(K_SW);
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i >= 3) begin
                checkVal("abort_pre_state", 32'(bus.state), 32'(S_M));
                checkVal("abort_pre_dm_we", 32'(bus.dm_we), 32'd1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        reset = 1'b1;
        #1;
        checkVal("abort_dm_we", 32'(bus.dm_we), 32'd0);
        checkVal("abort_enables", 32'(enVec), 32'd0);
        checkVal("abort_state", 32'(bus.state), 32'(S_F));
        checkVal("abort_retired", 32'(bus.retired), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkVal("abort_hold_enables", 32'(enVec), 32'd0);
        reset    = 1'b0;
        retModel = 0;
        $display("sw aborted by reset in MEM: state=%0d retired=%0d", bus.state, bus.retired);
    endtask

    initial begin
        bus.instr     = 32'h0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        reset         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("rst_enables", 32'(enVec), 32'd0);
            checkVal("rst_state", 32'(bus.state), 32'(S_F));
            checkVal("rst_retired", 32'(bus.retired), 32'd0);
        end
        reset = 1'b0;
        $display("reset released");

        runInstr(K_ORI, 32'h34011234, 0, 1'b0);
        runInstr(K_LW, 32'h8C220004, 3, 1'b0);
        runInstr(K_BEQ, genInstr(K_BEQ), 0, 1'b1);
        runInstr(K_BEQ, genInstr(K_BEQ), 0, 1'b0);
        runInstr(K_MDU, 32'h00220018, 0, 1'b0);
        runInstr(K_MFHI, genInstr(K_MFHI), 0, 1'b0);
        runInstr(K_MFLO, genInstr(K_MFLO), 0, 1'b0);
        swResetAbort();

        // wrap of the 4-bit retired counter from a fresh reset
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        retModel = 0;
        for (int i = 0; i < 15; i++) runRandom();
        checkVal("wrap_pre", 32'(bus.retired), 32'd15);
        runRandom();
        checkVal("wrap", 32'(bus.retired), 32'd0);

        for (int i = 0; i < 40; i++) runRandom();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle controller for the MIPS datapath, successor to the single-cycle decoder. It decodes the IR once per instruction and sequences it through FETCH/DECODE/EXEC/MEM/WB states, handshaking with a variable-latency data memory. It optionally sequences a fixed-latency multiply/divide unit and keeps a retired-instruction counter. It sits between IR/ALU-zero/memory-ready inputs and every datapath enable and mux select.

## Interface
- `CNT_W`, 32, width of retired-instruction counter
- `MDU_LAT`, 5, MDU busy cycles after start (legal range 1..255)

- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `instr` in 32: IR contents, stable from DECODE onward
- `zero` in 1: ALU equality result, valid in EXEC
- `mem_ready` in 1: data memory completes the current access this cycle
- `pc_we`, `ir_we`, `grf_we`, `dm_we` out 1: write enables
- `mem_req` out 1: data memory access request
- `reg_dst` out 2: 00 rd, 01 rt, 10 $31
- `wd_sel` out 2: 00 ALU, 01 DM, 10 PC (already PC+4), 11 HI/LO
- `alu_src` out 1: 1 = extended immediate
- `alu_op` out 4: 0 add, 1 sub, 2 or, 3 lui-shift
- `ext_sign` out 1: sign-extend (lw/sw/beq)
- `npc_sel` out 2: 00 PC+4, 01 branch, 10 j/jal target, 11 rs (jr)
- `mdu_start` out 1: one-cycle MDU launch
- `hilo_sel` out 1: 0 LO, 1 HI
- `illegal` out 1: one-cycle pulse on an undecodable instruction
- `state` out 3: current state (debug)
- `retired` out CNT_W: count of completed instructions

## Operation
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, MDUW 5. Values 6–7 are unreachable and return to FETCH.
- FETCH: `ir_we`=1, `pc_we`=1, `npc_sel`=00. Next state is DECODE.
- DECODE:
  - j: `pc_we`, `npc_sel`=10. Next state is FETCH.
  - jal: same as j, plus `grf_we`, `reg_dst`=10, `wd_sel`=10. Next state is FETCH.
  - jr: `pc_we`, `npc_sel`=11. Next state is FETCH.
  - nop (instr==0): next state is FETCH.
  - Illegal instruction: `illegal` pulse, next state is FETCH. Counts as retired.
  - All other instructions: next state is EXEC.
- EXEC:
  - addu/subu/ori/lui/mfhi/mflo: next state is WB.
  - lw/sw: next state is MEM.
  - beq: `pc_we`=`zero`, `npc_sel`=01. Next state is FETCH.
  - MDU ops: `mdu_start`=1. Next state is MDUW.
- MEM:
  - `mem_req`=1; `dm_we`=1 for sw.
  - Holds while `mem_ready`=0.
  - When `mem_ready`=1: lw goes to WB, sw goes to FETCH.
- WB: `grf_we`=1, with `reg_dst`/`wd_sel` per opcode. Next state is FETCH.
- MDUW: down-counter loads MDU_LAT-1 on entry. Next state is FETCH when the counter reads 0.
- Mux selects are combinational from `state` and `instr`. Every enable not listed for a state is 0.
- `retired` increments on each transition into FETCH from any non-FETCH state. It wraps to 0 after 2^CNT_W-1.

## Timing
- While `reset`=1 and after reset release: state=FETCH, counters=0.
- While `reset`=1, every enable, `mem_req`, `mdu_start` and `illegal` is forced to 0.
- The first fetch occurs on the first rising edge after `reset` falls.
- Cycle counts per instruction:
  - j/jal/jr/nop/illegal: 2
  - beq: 3
  - ALU ops and mfhi/mflo: 4
  - sw: 4+W, where W is the number of cycles with `mem_ready`=0
  - lw: 5+W
  - mult/div: 3+MDU_LAT
- `mem_req` stays high and the controller stays in MEM until `mem_ready`. A `mem_ready` outside MEM is ignored.
- `reset` asserted mid-MEM or mid-MDUW aborts immediately. There is no further `dm_we` or `grf_we`, and `retired` is not incremented.

## Configuration
- `MC_CTRL_MDU_EN` defined:
  - mult/multu/div/divu (funct 0x18/0x19/0x1A/0x1B) use the EXEC→MDUW path.
  - mfhi/mflo (0x10/0x12) write back with `wd_sel`=11 and `hilo_sel` set per instruction.
- `MC_CTRL_MDU_EN` undefined:
  - These six functs decode as illegal.
  - MDUW and its counter are not built.
  - `mdu_start` and `hilo_sel` are tied to 0.

## Structure
- Shared package `mc_pkg`:
  - state encodings
  - opcode/funct constants
  - `alu_op`, `npc_sel` and `wd_sel` encodings
- Sub-module `mc_decode`: purely combinational instruction classifier producing one-hot class flags.
- `mc_ctrl` contains the state register, the MDU counter, the retired counter and the output decode.

## Test plan
- Reset held 3 cycles, then released:
  - all enables are 0 during reset
  - cycle 1 shows `ir_we`=`pc_we`=1 and `state`=0
- ori $1,$0,0x1234 (0x34011234) → states 0,1,2,4. In WB: `grf_we`=1, `reg_dst`=01, `alu_op`=2, `alu_src`=1. Then `retired`=1.
- lw (0x8C220004) with `mem_ready` low 3 cycles → MEM lasts 4 cycles with `mem_req` high throughout, then WB with `wd_sel`=01. Total 8 cycles.
- beq, once with `zero`=1 and once with `zero`=0 → `pc_we` in EXEC equals `zero`, `npc_sel`=01. Each takes 3 cycles.
- MDU:
  - With MDU_EN and MDU_LAT=5, mult (0x00220018) → one `mdu_start` pulse, 5 cycles in MDUW, 8 cycles total.
  - Without MDU_EN, the same instruction gives an `illegal` pulse in DECODE.
- Reset asserted during MEM of sw → `dm_we` drops asynchronously, `state`=0, `retired` unchanged (reset to 0).
- With `retired` preset to all-ones (CNT_W=4, after 15 instructions), one more instruction → `retired` wraps to 0.
